axi_char_sink: RTL and testbench

Synthesizable AXI4 write-responder that terminates the system's character-output (UART) address window. It accepts write bursts from the interconnect and pushes the low byte of every strobed beat into a character FIFO. A downstream consumer drains the FIFO over a valid/ready byte stream. It returns protocol-correct B responses and answers reads with SLVERR, so the window is usable on silicon as well as in simulation.

---
 rtl/axi_char_sink.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_char_sink.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_char_sink.sv
// axi_char_sink_pkg: default AXI4 channel and request/response structs for
// the character sink (ID 6, address 32, data 32, user 1).
//
// axi_char_sink: AXI4 write-responder for the character-output window.
// The low byte of every strobed W beat goes into a character FIFO, which a
// consumer drains over a valid/ready byte stream. Writes get OKAY. Reads get
// SLVERR beats with zero data.
//
// Ports:
//   clk_i, rst_ni    clock, async active-low reset
//   axi_req_i        AXI4 slave request (aw/w/ar, b_ready, r_ready)
//   axi_resp_o       AXI4 slave response (readies, b, r)
//   char_o           FIFO head character (don't-care when empty)
//   char_valid_o     FIFO not empty
//   char_ready_i     consumer pops on valid & ready
//   fifo_usage_o     FIFO occupancy
//   dropped_o        pulse on a W handshake whose strb[0] is 0
package axi_char_sink_pkg;
  localparam int unsigned IdW   = 6;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned UserW = 1;

  typedef logic [IdW-1:0]     id_t;
  typedef logic [AddrW-1:0]   addr_t;
  typedef logic [DataW-1:0]   data_t;
  typedef logic [DataW/8-1:0] strb_t;
  typedef logic [UserW-1:0]   user_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_char_sink #(
  parameter int unsigned FifoDepth = 16,
  parameter int unsigned IdWidth   = 6,
  parameter type         req_t     = axi_char_sink_pkg::req_t,
  parameter type         resp_t    = axi_char_sink_pkg::resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  req_t                       axi_req_i,
  output resp_t                      axi_resp_o,
  output logic [7:0]                 char_o,
  output logic                       char_valid_o,
  input  logic                       char_ready_i,
  output logic [$clog2(FifoDepth):0] fifo_usage_o,
  output logic                       dropped_o
);
  import axi_char_sink_pkg::*;

  localparam int unsigned PtrW = $clog2(FifoDepth);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [IdWidth-1:0] aw_id_q, ar_id_q;
  logic [7:0]         ar_len_q, r_cnt_q;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic w_hs, push, pop, full, empty;

  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FifoDepth];

  // Address, burst shape and upper data lanes are deliberately ignored.
  logic unused_req;
  assign unused_req = ^axi_req_i;

  // ---------------- write FSM ----------------
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi_req_i.aw_valid) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = ~full;
        if (axi_req_i.w_valid && w_ready && axi_req_i.w.last) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign w_hs      = axi_req_i.w_valid & w_ready;
  assign push      = w_hs & axi_req_i.w.strb[0];
  assign dropped_o = w_hs & ~axi_req_i.w.strb[0];

  // ---------------- read FSM ----------------
  assign r_last = (r_cnt_q == ar_len_q);

  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (axi_req_i.ar_valid) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (axi_req_i.r_ready && r_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_id_q   <= '0;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      r_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      if (aw_ready && axi_req_i.aw_valid) aw_id_q <= axi_req_i.aw.id;
      if (ar_ready && axi_req_i.ar_valid) begin
        ar_id_q  <= axi_req_i.ar.id;
        ar_len_q <= axi_req_i.ar.len;
        r_cnt_q  <= '0;
      end else if (r_valid && axi_req_i.r_ready) begin
        r_cnt_q <= r_cnt_q + 8'd1;
      end
    end
  end

  // ---------------- character FIFO ----------------
  // Pointers carry one extra wrap bit: equal indices with differing wrap
  // bits means full, identical pointers means empty.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop          = ~empty & char_ready_i;
  assign fifo_usage_o = wr_ptr_q - rd_ptr_q;
  assign char_valid_o = ~empty;
  assign char_o       = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; resetting the pointers makes every entry
  // unreadable, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= axi_req_i.w.data[7:0];
  end

  // ---------------- response assembly ----------------
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b.id     = aw_id_q;
    axi_resp_o.b.resp   = RESP_OKAY;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r.id     = ar_id_q;
    axi_resp_o.r.resp   = RESP_SLVERR;
    axi_resp_o.r.last   = r_valid & r_last;
  end
endmodule

// File: tb/tb_axi_char_sink.sv
// Directed bench for axi_char_sink. Inputs change on the falling edge and
// outputs are sampled 1 time unit later; the rising edge commits handshakes.
module tb_axi_char_sink;
  import axi_char_sink_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  req_t       req;
  resp_t      resp;
  logic [7:0] char;
  logic       char_valid;
  logic       char_ready;
  logic [4:0] usage;
  logic       dropped;

  int n_checks = 0;
  int n_pass   = 0;

  // Written only by the monitor; tests index from a recorded base.
  logic [7:0] pop_q[$];
  int         drop_cnt = 0;

  localparam logic [7:0] BURST [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
  localparam bit   [8:1] RR_PAT    = 8'b00101010;

  always #5 clk = ~clk;

  axi_char_sink #(.FifoDepth(16), .IdWidth(6)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .axi_req_i    (req),
    .axi_resp_o   (resp),
    .char_o       (char),
    .char_valid_o (char_valid),
    .char_ready_i (char_ready),
    .fifo_usage_o (usage),
    .dropped_o    (dropped)
  );

  always begin
    @(negedge clk);
    #2;
    if (rst_n && char_valid && char_ready) pop_q.push_back(char);
    if (rst_n && dropped) drop_cnt++;
  end

  task automatic next();
    @(negedge clk);
  endtask

  // Stimulus only: one single-beat write with bounded waits on each channel.
  task automatic write_byte(input logic [5:0] id, input logic [7:0] data,
                            output logic [5:0] bid);
    int t;
    req.aw_valid = 1'b1; req.aw.id = id;
    t = 0; #1;
    while (!resp.aw_ready && t < 50) begin next(); #1; t++; end
    if (t >= 50) begin n_checks++; $display("FAIL aw_timeout: aw_ready low for %0d cycles", t); end
    next();
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1; req.w.data = {24'h0, data}; req.w.strb = 4'h1; req.w.last = 1'b1;
    t = 0; #1;
    while (!resp.w_ready && t < 50) begin next(); #1; t++; end
    if (t >= 50) begin n_checks++; $display("FAIL w_timeout: w_ready low for %0d cycles", t); end
    next();
    req.w_valid = 1'b0; req.b_ready = 1'b1;
    t = 0; #1;
    while (!resp.b_valid && t < 50) begin next(); #1; t++; end
    if (t >= 50) begin n_checks++; $display("FAIL b_timeout: b_valid low for %0d cycles", t); end
    bid = resp.b.id;
    next();
    req.b_ready = 1'b0;
  endtask

  task automatic drain();
    int t;
    char_ready = 1'b1;
    t = 0; #1;
    while (char_valid && t < 60) begin next(); #1; t++; end
    if (t >= 60) begin n_checks++; $display("FAIL drain_timeout: FIFO still valid after %0d cycles", t); end
    next();
    char_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; char_ready = 1'b0;
    repeat (2) next();
    #1;
    n_checks++; if (resp.aw_ready !== 1'b1) $display("FAIL reset_aw_ready: got %b want 1", resp.aw_ready); else n_pass++;
    n_checks++; if (resp.ar_ready !== 1'b1) $display("FAIL reset_ar_ready: got %b want 1", resp.ar_ready); else n_pass++;
    n_checks++; if ({resp.w_ready, resp.b_valid, resp.r_valid} !== 3'b000)
      $display("FAIL reset_valids: w_ready/b_valid/r_valid got %b want 000", {resp.w_ready, resp.b_valid, resp.r_valid}); else n_pass++;
    n_checks++; if ({char_valid, dropped, usage} !== 7'd0)
      $display("FAIL reset_fifo: valid=%b dropped=%b usage=%0d want 0/0/0", char_valid, dropped, usage); else n_pass++;
    next();
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_single_write();
    char_ready = 1'b1;
    req.aw_valid = 1'b1; req.aw.id = 6'd5;
    #1;
    n_checks++; if (resp.aw_ready !== 1'b1) $display("FAIL single_aw_ready: got %b want 1", resp.aw_ready); else n_pass++;
    next();
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1; req.w.data = 32'h41; req.w.strb = 4'h1; req.w.last = 1'b1;
    #1;
    n_checks++; if (resp.w_ready !== 1'b1) $display("FAIL single_w_ready: got %b want 1", resp.w_ready); else n_pass++;
    n_checks++; if (char_valid !== 1'b0 || usage !== 5'd0)
      $display("FAIL single_no_bypass: valid=%b usage=%0d want 0/0", char_valid, usage); else n_pass++;
    next();
    req.w_valid = 1'b0; req.b_ready = 1'b1;
    #1;
    n_checks++; if (char_valid !== 1'b1 || char !== 8'h41)
      $display("FAIL single_char: valid=%b char=%h want 1/41", char_valid, char); else n_pass++;
    n_checks++; if (usage !== 5'd1) $display("FAIL single_usage1: got %0d want 1", usage); else n_pass++;
    n_checks++; if (resp.b_valid !== 1'b1 || resp.b.id !== 6'd5 || resp.b.resp !== 2'b00)
      $display("FAIL single_b: valid=%b id=%0d resp=%b want 1/5/00", resp.b_valid, resp.b.id, resp.b.resp); else n_pass++;
    next();
    req.b_ready = 1'b0;
    #1;
    n_checks++; if (usage !== 5'd0 || char_valid !== 1'b0)
      $display("FAIL single_usage0: usage=%0d valid=%b want 0/0", usage, char_valid); else n_pass++;
    n_checks++; if (resp.b_valid !== 1'b0 || resp.aw_ready !== 1'b1)
      $display("FAIL single_back_idle: b_valid=%b aw_ready=%b want 0/1", resp.b_valid, resp.aw_ready); else n_pass++;
    next();
    char_ready = 1'b0;
  endtask

  task automatic test_burst_drop();
    int base;
    int drops0;
    base = pop_q.size(); drops0 = drop_cnt;
    char_ready = 1'b0;
    req.aw_valid = 1'b1; req.aw.id = 6'd9; req.aw.len = 8'd3;
    next();
    req.aw_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      req.w_valid = 1'b1; req.w.data = {24'h0, BURST[b]};
      req.w.strb = (b == 2) ? 4'h0 : 4'h1; req.w.last = (b == 3);
      #1;
      n_checks++; if (resp.w_ready !== 1'b1 || resp.b_valid !== 1'b0)
        $display("FAIL burst_beat%0d: w_ready=%b b_valid=%b want 1/0", b, resp.w_ready, resp.b_valid); else n_pass++;
      n_checks++; if (dropped !== (b == 2))
        $display("FAIL burst_dropped%0d: got %b want %b", b, dropped, (b == 2)); else n_pass++;
      next();
    end
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    #1;
    n_checks++; if (resp.b_valid !== 1'b1 || resp.b.id !== 6'd9)
      $display("FAIL burst_b: valid=%b id=%0d want 1/9", resp.b_valid, resp.b.id); else n_pass++;
    next();
    req.b_ready = 1'b0;
    #1;
    n_checks++; if (resp.b_valid !== 1'b0) $display("FAIL burst_single_b: b_valid got %b want 0", resp.b_valid); else n_pass++;
    n_checks++; if (usage !== 5'd3) $display("FAIL burst_usage: got %0d want 3", usage); else n_pass++;
    n_checks++; if (drop_cnt - drops0 !== 1) $display("FAIL burst_drop_count: got %0d want 1", drop_cnt - drops0); else n_pass++;
    next();
    drain();
    n_checks++; if (pop_q.size() - base !== 3) $display("FAIL burst_pop_count: got %0d want 3", pop_q.size() - base);
    else begin
      n_pass++;
      n_checks++; if ({pop_q[base], pop_q[base+1], pop_q[base+2]} !== 24'h414244)
        $display("FAIL burst_order: got %h%h%h want 414244", pop_q[base], pop_q[base+1], pop_q[base+2]); else n_pass++;
    end
  endtask

  task automatic test_fill_wrap();
    int base;
    logic [5:0] bid;
    base = pop_q.size();
    char_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(6'(i), 8'(8'h60 + i), bid);
    #1;
    n_checks++; if (usage !== 5'd16 || char_valid !== 1'b1)
      $display("FAIL fill_usage16: usage=%0d valid=%b want 16/1", usage, char_valid); else n_pass++;
    next();
    req.aw_valid = 1'b1; req.aw.id = 6'd16;
    next();
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1; req.w.data = 32'h70; req.w.strb = 4'h1; req.w.last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (resp.w_ready !== 1'b0) $display("FAIL fill_w_ready_full%0d: got %b want 0", k, resp.w_ready); else n_pass++;
      next();
    end
    char_ready = 1'b1;
    #1;
    n_checks++; if (resp.w_ready !== 1'b0 || char !== 8'h60)
      $display("FAIL fill_pop_cycle: w_ready=%b char=%h want 0/60", resp.w_ready, char); else n_pass++;
    next();
    char_ready = 1'b0;
    #1;
    n_checks++; if (resp.w_ready !== 1'b1) $display("FAIL fill_w_ready_after_pop: got %b want 1", resp.w_ready); else n_pass++;
    next();
    req.w_valid = 1'b0; req.b_ready = 1'b1;
    #1;
    n_checks++; if (resp.b_valid !== 1'b1 || usage !== 5'd16)
      $display("FAIL fill_b17: b_valid=%b usage=%0d want 1/16", resp.b_valid, usage); else n_pass++;
    next();
    req.b_ready = 1'b0;
    char_ready = 1'b1;
    for (int i = 17; i < 20; i++) write_byte(6'(i), 8'(8'h60 + i), bid);
    drain();
    n_checks++; if (pop_q.size() - base !== 20) $display("FAIL fill_pop_count: got %0d want 20", pop_q.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 20; i++) begin
        n_checks++; if (pop_q[base+i] !== 8'(8'h60 + i))
          $display("FAIL fill_order%0d: got %h want %h", i, pop_q[base+i], 8'(8'h60 + i)); else n_pass++;
      end
    end
  endtask

  task automatic test_push_pop();
    int base;
    logic [5:0] bid;
    base = pop_q.size();
    char_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_byte(6'(i), 8'(8'h30 + i), bid);
    req.aw_valid = 1'b1; req.aw.id = 6'd8;
    #1;
    n_checks++; if (usage !== 5'd8) $display("FAIL pp_usage_before: got %0d want 8", usage); else n_pass++;
    next();
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1; req.w.data = 32'h38; req.w.strb = 4'h1; req.w.last = 1'b1;
    char_ready = 1'b1;
    #1;
    n_checks++; if (resp.w_ready !== 1'b1 || char !== 8'h30)
      $display("FAIL pp_cycle: w_ready=%b char=%h want 1/30", resp.w_ready, char); else n_pass++;
    next();
    req.w_valid = 1'b0; char_ready = 1'b0; req.b_ready = 1'b1;
    #1;
    n_checks++; if (usage !== 5'd8) $display("FAIL pp_usage_after: got %0d want 8", usage); else n_pass++;
    next();
    req.b_ready = 1'b0;
    drain();
    n_checks++; if (pop_q.size() - base !== 9) $display("FAIL pp_pop_count: got %0d want 9", pop_q.size() - base);
    else begin
      n_pass++;
      for (int i = 0; i < 9; i++) begin
        n_checks++; if (pop_q[base+i] !== 8'(8'h30 + i))
          $display("FAIL pp_order%0d: got %h want %h", i, pop_q[base+i], 8'(8'h30 + i)); else n_pass++;
      end
    end
  endtask

  task automatic test_read_concurrent_write();
    int beats;
    beats = 0;
    char_ready = 1'b0;
    req.ar_valid = 1'b1; req.ar.id = 6'd3; req.ar.len = 8'd2;
    req.aw_valid = 1'b1; req.aw.id = 6'd7;
    #1;
    n_checks++; if (resp.ar_ready !== 1'b1 || resp.aw_ready !== 1'b1 || resp.r_valid !== 1'b0)
      $display("FAIL rd_accept: ar_ready=%b aw_ready=%b r_valid=%b want 1/1/0", resp.ar_ready, resp.aw_ready, resp.r_valid); else n_pass++;
    next();
    req.ar_valid = 1'b0; req.aw_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      req.r_ready = RR_PAT[c];
      req.w_valid = (c == 1);
      req.w.data = 32'h52; req.w.strb = 4'h1; req.w.last = 1'b1;
      req.b_ready = (c == 2);
      #1;
      if (resp.r_valid) begin
        n_checks++; if (resp.r.data !== '0 || resp.r.resp !== 2'b10 || resp.r.id !== 6'd3)
          $display("FAIL rd_payload_c%0d: data=%h resp=%b id=%0d want 0/10/3", c, resp.r.data, resp.r.resp, resp.r.id); else n_pass++;
        n_checks++; if (resp.r.last !== (beats == 2))
          $display("FAIL rd_last_c%0d: got %b want %b", c, resp.r.last, (beats == 2)); else n_pass++;
        if (req.r_ready) beats++;
      end
      if (c == 1) begin
        n_checks++; if (resp.w_ready !== 1'b1) $display("FAIL rd_wr_w_ready: got %b want 1", resp.w_ready); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (resp.b_valid !== 1'b1 || resp.b.id !== 6'd7 || resp.b.resp !== 2'b00)
          $display("FAIL rd_wr_b: valid=%b id=%0d resp=%b want 1/7/00", resp.b_valid, resp.b.id, resp.b.resp); else n_pass++;
      end
      next();
    end
    req.r_ready = 1'b0; req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b0;
    #1;
    n_checks++; if (beats !== 3) $display("FAIL rd_beats: got %0d want 3", beats); else n_pass++;
    n_checks++; if (resp.r_valid !== 1'b0 || resp.ar_ready !== 1'b1)
      $display("FAIL rd_idle: r_valid=%b ar_ready=%b want 0/1", resp.r_valid, resp.ar_ready); else n_pass++;
    n_checks++; if (usage !== 5'd1 || char !== 8'h52)
      $display("FAIL rd_wr_char: usage=%0d char=%h want 1/52", usage, char); else n_pass++;
    next();
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int base;
    logic [5:0] bid;
    char_ready = 1'b0;
    req.aw_valid = 1'b1; req.aw.id = 6'd2; req.aw.len = 8'd2;
    next();
    req.aw_valid = 1'b0;
    req.w_valid = 1'b1; req.w.data = 32'h71; req.w.strb = 4'h1; req.w.last = 1'b0;
    next();
    req.w.data = 32'h72;
    #1;
    n_checks++; if (usage !== 5'd1) $display("FAIL rst_mid_usage_before: got %0d want 1", usage); else n_pass++;
    next();
    rst_n = 1'b0;
    #1;
    n_checks++; if (usage !== 5'd0 || char_valid !== 1'b0 || dropped !== 1'b0)
      $display("FAIL rst_mid_fifo: usage=%0d valid=%b dropped=%b want 0/0/0", usage, char_valid, dropped); else n_pass++;
    n_checks++; if (resp.aw_ready !== 1'b1 || resp.ar_ready !== 1'b1 || resp.w_ready !== 1'b0 || resp.b_valid !== 1'b0)
      $display("FAIL rst_mid_axi: aw=%b ar=%b w=%b b=%b want 1/1/0/0", resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid); else n_pass++;
    req = '0;
    next();
    rst_n = 1'b1;
    next();
    #1;
    n_checks++; if (resp.b_valid !== 1'b0) $display("FAIL rst_mid_no_b: b_valid got %b want 0", resp.b_valid); else n_pass++;
    next();
    base = pop_q.size();
    write_byte(6'd4, 8'h5A, bid);
    n_checks++; if (bid !== 6'd4) $display("FAIL rst_after_bid: got %0d want 4", bid); else n_pass++;
    drain();
    n_checks++; if (pop_q.size() - base !== 1) $display("FAIL rst_after_count: got %0d want 1", pop_q.size() - base);
    else begin
      n_pass++;
      n_checks++; if (pop_q[base] !== 8'h5A) $display("FAIL rst_after_char: got %h want 5a", pop_q[base]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_drop();
    test_fill_wrap();
    test_push_pop();
    test_read_concurrent_write();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
